// File: rtl/coco_bucket_dump.sv
// CocoSketch bucket read-out engine: scans every bucket once, streams the heavy
// hitters out on a valid/ready port and optionally zeroes each bucket it reads.
module coco_bucket_dump #(
  parameter int RAM_PTR = 4,
  parameter int KEY_W   = 64,
  parameter int CNT_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [CNT_W-1:0]       threshold,
  input  logic                   clear_en,
  output logic                   busy,
  output logic                   done,
  output logic [RAM_PTR:0]       emit_cnt,
  output logic                   ram_rd_en,
  output logic [RAM_PTR-1:0]     ram_rd_addr,
  input  logic [KEY_W+CNT_W-1:0] ram_rd_data,
  output logic                   ram_wr_en,
  output logic [RAM_PTR-1:0]     ram_wr_addr,
  output logic [KEY_W+CNT_W-1:0] ram_wr_data,
  output logic [KEY_W-1:0]       out_key,
  output logic [CNT_W-1:0]       out_cnt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2:0]             state_dbg
);

  // Output stream: a beat transfers on a rising clk edge where out_valid and
  // out_ready are both high; once raised, out_valid and the payload stay
  // unchanged until that edge, and out_ready alone never has any effect.

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CHK  = 3'd2,
    OUT  = 3'd3,
    FIN  = 3'd4
  } state_t;

  localparam logic [RAM_PTR-1:0] ADDR_ONE = RAM_PTR'(1);
  localparam logic [RAM_PTR:0]   EMIT_ONE = (RAM_PTR + 1)'(1);

  state_t             state;
  logic [RAM_PTR-1:0] addr;
  logic [CNT_W-1:0]   thr_reg;
  logic               clr_reg;

  logic [CNT_W-1:0] rd_cnt;
  logic [KEY_W-1:0] rd_key;
  logic             pass;
  logic             last;
  logic             advance;

  assign rd_cnt      = ram_rd_data[CNT_W-1:0];
  assign rd_key      = ram_rd_data[KEY_W+CNT_W-1:CNT_W];
  assign pass        = (rd_cnt != '0) && (rd_cnt >= thr_reg);
  assign last        = (addr == {RAM_PTR{1'b1}});
  assign advance     = ((state == CHK) && !pass) || ((state == OUT) && out_ready);
  assign ram_wr_data = '0;
  assign state_dbg   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr        <= '0;
      thr_reg     <= '0;
      clr_reg     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      emit_cnt    <= '0;
      ram_rd_en   <= 1'b0;
      ram_rd_addr <= '0;
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      out_key     <= '0;
      out_cnt     <= '0;
      out_valid   <= 1'b0;
    end else begin
      done      <= 1'b0;
      ram_rd_en <= 1'b0;
      ram_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            thr_reg     <= threshold;
            clr_reg     <= clear_en;
            addr        <= '0;
            emit_cnt    <= '0;
            busy        <= 1'b1;
            ram_rd_en   <= 1'b1;
            ram_rd_addr <= '0;
            state       <= RD;
          end
        end
        RD: begin
          // The clear lands in CHK, after the read data has already been captured.
          ram_wr_en   <= clr_reg;
          ram_wr_addr <= addr;
          state       <= CHK;
        end
        CHK: begin
          if (pass) begin
            out_key   <= rd_key;
            out_cnt   <= rd_cnt;
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            emit_cnt  <= emit_cnt + EMIT_ONE;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // Shared step to the next bucket, or to FIN after the last one (no wrap).
      if (advance) begin
        if (last) begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= FIN;
        end else begin
          addr        <= addr + ADDR_ONE;
          ram_rd_en   <= 1'b1;
          ram_rd_addr <= addr + ADDR_ONE;
          state       <= RD;
        end
      end
    end
  end

endmodule

// File: tb/tb_coco_bucket_dump.sv
// Bench for coco_bucket_dump: behavioural bucket RAM, scan driver with an
// expected-beat queue, and one task per scenario.
module tb_coco_bucket_dump;

  localparam int RAM_PTR = 4;
  localparam int KEY_W   = 64;
  localparam int CNT_W   = 32;
  localparam int W       = KEY_W + CNT_W;
  localparam int NB      = 1 << RAM_PTR;
  localparam int BASE    = 2 * NB + 1;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [CNT_W-1:0]   threshold;
  logic               clear_en;
  logic               busy;
  logic               done;
  logic [RAM_PTR:0]   emit_cnt;
  logic               ram_rd_en;
  logic [RAM_PTR-1:0] ram_rd_addr;
  logic [W-1:0]       ram_rd_data = '0;
  logic               ram_wr_en;
  logic [RAM_PTR-1:0] ram_wr_addr;
  logic [W-1:0]       ram_wr_data;
  logic [KEY_W-1:0]   out_key;
  logic [CNT_W-1:0]   out_cnt;
  logic               out_valid;
  logic               out_ready;
  logic [2:0]         state_dbg;

  coco_bucket_dump #(.RAM_PTR(RAM_PTR), .KEY_W(KEY_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .threshold(threshold),
    .clear_en(clear_en), .busy(busy), .done(done), .emit_cnt(emit_cnt),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .out_key(out_key), .out_cnt(out_cnt), .out_valid(out_valid),
    .out_ready(out_ready), .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bucket RAM: registered read; clears are applied by the scan driver.
  logic [W-1:0] mem [NB];
  always @(posedge clk) begin
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
  end

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int done_cyc, first_valid, first_rd, beats, n_exp, exp_rd, exp_wr, busy_bad;

  task automatic clear_mem();
    for (int i = 0; i < NB; i++) mem[i] = '0;
  endtask

  task automatic fill_pattern();
    clear_mem();
    mem[3]  = {64'hA, 32'd5};
    mem[7]  = {64'hB, 32'd1};
    mem[15] = {64'hC, 32'd9};
  endtask

  // Starts a scan, pushes the expected beats, then runs it to done while
  // shaping out_ready and scoring every beat, read and clear as it happens.
  task automatic run_scan(input logic [CNT_W-1:0] thr, input logic clr, input int stall,
                          input logic idle_rdy, input int restart_at, input logic restart_on_done);
    int cyc;
    int st;
    logic prev_stall;
    logic [W-1:0] prev_beat;
    logic [W-1:0] want;
    exp_q.delete();
    n_exp = 0;
    for (int i = 0; i < NB; i++) begin
      if (mem[i][CNT_W-1:0] != 0 && mem[i][CNT_W-1:0] >= thr) begin
        exp_q.push_back(mem[i]);
        n_exp++;
      end
    end
    beats = 0; exp_rd = 0; exp_wr = 0; busy_bad = 0;
    done_cyc = -1; first_valid = -1; first_rd = -1;
    cyc = 0; st = 0; prev_stall = 1'b0; prev_beat = '0;
    @(posedge clk); #1;
    threshold = thr; clear_en = clr; start = 1'b1; out_ready = idle_rdy;
    while (done_cyc < 0 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == restart_at);
      if (out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (st < stall) begin
          out_ready = 1'b0;
          st++;
        end else begin
          out_ready = 1'b1;
        end
      end else begin
        st = 0;
        out_ready = idle_rdy;
      end
      if (ram_rd_en && first_rd < 0) first_rd = cyc;
      if (done) begin
        done_cyc = cyc;
        start = restart_on_done;
      end else begin
        if (!busy) busy_bad++;
        @(negedge clk);
        if (ram_rd_en) begin
          checks++;
          if (ram_rd_addr !== exp_rd[RAM_PTR-1:0] || out_valid || exp_rd >= NB) begin
            errors++;
            $display("FAIL rd_seq cyc %0d got addr %0d valid %0b want addr %0d valid 0", cyc, ram_rd_addr, out_valid, exp_rd);
          end
          exp_rd++;
        end
        if (ram_wr_en) begin
          checks++;
          if (!clr || ram_wr_addr !== exp_wr[RAM_PTR-1:0] || ram_wr_data !== '0) begin
            errors++;
            $display("FAIL clear_wr cyc %0d got addr %0d data %0h clr %0b want addr %0d data 0", cyc, ram_wr_addr, ram_wr_data, clr, exp_wr);
          end
          mem[ram_wr_addr] = '0;
          exp_wr++;
        end
        if (prev_stall) begin
          checks++;
          if (!out_valid || {out_key, out_cnt} !== prev_beat) begin
            errors++;
            $display("FAIL stall_hold cyc %0d got valid %0b beat %0h want valid 1 beat %0h", cyc, out_valid, {out_key, out_cnt}, prev_beat);
          end
        end
        if (out_valid && out_ready) begin
          beats++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL beat cyc %0d got %0h want no beat", cyc, {out_key, out_cnt});
          end else begin
            want = exp_q.pop_front();
            if ({out_key, out_cnt} !== want) begin
              errors++;
              $display("FAIL beat cyc %0d got %0h want %0h", cyc, {out_key, out_cnt}, want);
            end
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_beat  = {out_key, out_cnt};
      end
    end
    if (done_cyc < 0) begin
      checks++; errors++;
      $display("FAIL scan_timeout got no done want done within 2000 cycles");
    end
    @(posedge clk); #1;
    start = 1'b0;
    out_ready = idle_rdy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; threshold = '0; clear_en = 1'b0; out_ready = 1'b0;
    clear_mem();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, out_valid, ram_rd_en, ram_wr_en} !== 5'b0 || emit_cnt !== '0 ||
        out_key !== '0 || out_cnt !== '0 || ram_rd_addr !== '0 || ram_wr_addr !== '0 || state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL reset_state got busy %0b done %0b valid %0b rd %0b wr %0b emit %0d state %0d want all 0",
               busy, done, out_valid, ram_rd_en, ram_wr_en, emit_cnt, state_dbg);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ram_rd_en !== 1'b0 || state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL idle_no_start got busy %0b rd %0b state %0d want 0 0 0", busy, ram_rd_en, state_dbg);
    end
  endtask

  task automatic test_empty_scan();
    clear_mem();
    run_scan(32'd0, 1'b0, 0, 1'b1, 0, 1'b0);
    checks++;
    if (done_cyc != BASE || first_rd != 1 || first_valid != -1) begin
      errors++;
      $display("FAIL empty_timing got done %0d first_rd %0d first_valid %0d want %0d 1 -1", done_cyc, first_rd, first_valid, BASE);
    end
    checks++;
    if (emit_cnt !== 5'd0 || beats != 0 || exp_rd != NB || busy_bad != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_counts got emit %0d beats %0d reads %0d busy_bad %0d busy %0b want 0 0 %0d 0 0", emit_cnt, beats, exp_rd, busy_bad, busy, NB);
    end
  endtask

  task automatic test_threshold();
    fill_pattern();
    run_scan(32'd2, 1'b0, 0, 1'b1, 0, 1'b0);
    checks++;
    if (done_cyc != BASE + 2 || beats != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL thr_scan got done %0d beats %0d left %0d want %0d 2 0", done_cyc, beats, exp_q.size(), BASE + 2);
    end
    checks++;
    if (emit_cnt !== 5'd2) begin
      errors++;
      $display("FAIL thr_emit_cnt got %0d want 2", emit_cnt);
    end
  endtask

  task automatic test_backpressure();
    fill_pattern();
    run_scan(32'd0, 1'b0, 5, 1'b0, 0, 1'b0);
    checks++;
    if (done_cyc != BASE + 3 * 6 || beats != 3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_scan got done %0d beats %0d left %0d want %0d 3 0", done_cyc, beats, exp_q.size(), BASE + 18);
    end
    checks++;
    if (emit_cnt !== 5'd3 || exp_rd != NB) begin
      errors++;
      $display("FAIL bp_counts got emit %0d reads %0d want 3 %0d", emit_cnt, exp_rd, NB);
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < NB; i++) begin
      mem[i][W-1:CNT_W]   = {$urandom, $urandom};
      mem[i][CNT_W-1:0]   = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
    end
    mem[0][CNT_W-1:0] = 32'($urandom_range(1, 50));
    run_scan(32'd0, 1'b1, 0, 1'b1, 0, 1'b0);
    checks++;
    if (exp_wr != NB || first_valid != 3 || done_cyc != BASE + n_exp) begin
      errors++;
      $display("FAIL clr_scan got writes %0d first_valid %0d done %0d want %0d 3 %0d", exp_wr, first_valid, done_cyc, NB, BASE + n_exp);
    end
    checks++;
    if (emit_cnt !== 5'(n_exp) || exp_q.size() != 0) begin
      errors++;
      $display("FAIL clr_emit got %0d left %0d want %0d 0", emit_cnt, exp_q.size(), n_exp);
    end
    run_scan(32'd0, 1'b0, 0, 1'b1, 0, 1'b0);
    checks++;
    if (beats != 0 || emit_cnt !== 5'd0 || done_cyc != BASE || exp_wr != 0) begin
      errors++;
      $display("FAIL clr_rescan got beats %0d emit %0d done %0d writes %0d want 0 0 %0d 0", beats, emit_cnt, done_cyc, exp_wr, BASE);
    end
  endtask

  task automatic test_reset_abort();
    logic found;
    fill_pattern();
    found = 1'b0;
    @(posedge clk); #1;
    threshold = '0; clear_en = 1'b0; start = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (out_valid && out_cnt == 32'd1) begin
        found = 1'b1;
        out_ready = 1'b0;
      end else begin
        out_ready = out_valid;
      end
    end
    checks++;
    if (!found || out_key !== 64'hB || emit_cnt !== 5'd1) begin
      errors++;
      $display("FAIL abort_reach got found %0b key %0h emit %0d want 1 b 1", found, out_key, emit_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, out_valid, ram_rd_en, ram_wr_en} !== 5'b0 || emit_cnt !== '0 ||
        out_key !== '0 || out_cnt !== '0 || ram_rd_addr !== '0 || ram_wr_addr !== '0 || state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL abort_async got busy %0b valid %0b emit %0d key %0h cnt %0d state %0d want all 0",
               busy, out_valid, emit_cnt, out_key, out_cnt, state_dbg);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_scan(32'd0, 1'b0, 0, 1'b1, 0, 1'b0);
    checks++;
    if (first_rd != 1 || beats != 3 || emit_cnt !== 5'd3 || done_cyc != BASE + 3) begin
      errors++;
      $display("FAIL abort_rescan got first_rd %0d beats %0d emit %0d done %0d want 1 3 3 %0d", first_rd, beats, emit_cnt, done_cyc, BASE + 3);
    end
  endtask

  task automatic test_restart_ignored();
    fill_pattern();
    run_scan(32'd2, 1'b0, 0, 1'b1, 10, 1'b1);
    checks++;
    if (done_cyc != BASE + 2 || beats != 2 || exp_rd != NB || emit_cnt !== 5'd2) begin
      errors++;
      $display("FAIL restart_mid got done %0d beats %0d reads %0d emit %0d want %0d 2 %0d 2", done_cyc, beats, exp_rd, emit_cnt, BASE + 2, NB);
    end
    checks++;
    if (busy !== 1'b0 || ram_rd_en !== 1'b0 || state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL restart_on_done got busy %0b rd %0b state %0d want 0 0 0", busy, ram_rd_en, state_dbg);
    end
  endtask

  initial begin
    test_reset();
    test_empty_scan();
    test_threshold();
    test_backpressure();
    test_clear();
    test_reset_abort();
    test_restart_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coco_bucket_dump.md
Name: coco_bucket_dump

Overview:
- Read-out engine for the CocoSketch bucket RAM; it is the reader counterpart to the insert pipeline (CRC hash followed by the update stage), which only writes buckets.
- After an insert phase, it scans every bucket address in order and reads {key, count}.
- Buckets that pass a heavy-hitter threshold are emitted on a valid/ready stream for host or report logic.
- Each bucket can optionally be cleared as it is read, so the sketch is ready for the next measurement epoch.

Parameters:
- RAM_PTR, 4, bucket address width; the block scans 2^RAM_PTR buckets.
- KEY_W, 64, key field width; matches the 64-bit element.
- CNT_W, 32, counter field width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a scan; ignored while busy=1.
- threshold  in  CNT_W  minimum count to emit; sampled on an accepted start.
- clear_en  in  1  zero each bucket after reading it; sampled on an accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the scan completes.
- emit_cnt  out  RAM_PTR+1  number of buckets emitted in the current or last scan.
- ram_rd_en  out  1  bucket RAM read enable.
- ram_rd_addr  out  RAM_PTR  bucket RAM read address.
- ram_rd_data  in  KEY_W+CNT_W  read data; key occupies the upper bits, count the lower bits. Valid exactly 1 cycle after ram_rd_en.
- ram_wr_en  out  1  clear-write enable.
- ram_wr_addr  out  RAM_PTR  clear-write address.
- ram_wr_data  out  KEY_W+CNT_W  always all zeros.
- out_key  out  KEY_W  emitted key.
- out_cnt  out  CNT_W  emitted count.
- out_valid  out  1  output stream valid.
- out_ready  in  1  output stream ready.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - busy, done, out_valid, ram_rd_en and ram_wr_en are 0.
  - emit_cnt, out_key, out_cnt, ram_rd_addr and ram_wr_addr are 0.
  - Reset asserted mid-scan aborts the scan immediately: no done pulse, and any pending output is dropped.
- FSM states: IDLE, RD, CHK, OUT, FIN.
  - IDLE: on start=1, register threshold and clear_en, set addr=0, clear emit_cnt, set busy=1, go to RD.
  - RD: assert ram_rd_en=1 with ram_rd_addr=addr for exactly one cycle, then go to CHK.
  - CHK: ram_rd_data is valid in this state. Let cnt be the low CNT_W bits.
    - If clear_en: ram_wr_en=1, ram_wr_addr=addr, ram_wr_data=0, in this cycle only.
    - pass = (cnt != 0) && (cnt >= threshold_reg).
    - If pass: load out_key/out_cnt, set out_valid=1, go to OUT.
    - Otherwise advance the address.
  - OUT: hold out_valid, out_key and out_cnt stable until out_ready=1 while out_valid=1.
    - On that handshake: out_valid drops the next cycle, emit_cnt increments, then advance the address.
  - Advance: if addr == 2^RAM_PTR-1, go to FIN; otherwise addr+1 and go to RD. The address never wraps.
  - FIN: done=1 for one cycle, busy=0, go to IDLE. emit_cnt holds its value until the next accepted start.
- Throughput: at least 2 cycles per bucket (RD, CHK), plus the OUT time for emitted buckets. Exactly one RAM read is outstanding at a time.
- Latency: start accepted at cycle T → first ram_rd_en at T+1 → earliest out_valid at T+3.
- Boundary conditions:
  - threshold=0: all non-empty buckets are emitted; empty buckets (count 0) are never emitted.
  - out_ready held high when out_valid rises: handshake completes in the first OUT cycle.
  - out_ready may be high while out_valid=0; this has no effect.
  - start in the same cycle as the done pulse: ignored; a new start is accepted only in IDLE.
- Clear write happens in CHK regardless of pass and regardless of backpressure, so a bucket is cleared even if its output is stalled. The read-modify-write to the same address is safe because the read completed in the preceding cycle.
- The block never writes the RAM while clear_en_reg=0.
- Arithmetic: the count comparison is unsigned. emit_cnt saturates naturally because at most 2^RAM_PTR buckets exist, which fits in RAM_PTR+1 bits.

Test Plan:
1. RAM_PTR=4, all 16 buckets zero, start with threshold=0 → no out_valid, done pulses at T+33 (start accepted at T, 16×2 RD/CHK cycles), emit_cnt=0.
2. Buckets 3 {key 0xA, cnt 5}, 7 {key 0xB, cnt 1}, 15 {key 0xC, cnt 9}, threshold=2, out_ready=1 → emits (0xA,5) then (0xC,9) in address order, emit_cnt=2; bucket 15 is emitted before done.
3. Same contents as scenario 2, threshold=0, out_ready low for 5 cycles on each beat → out_key/out_cnt/out_valid stay stable throughout the stall; 3 beats total; no read is issued during OUT.
4. clear_en=1, threshold=0, buckets populated → ram_wr_en fires 16 times at addresses 0..15 with zero data; a second scan emits nothing.
5. rst_n pulsed low while in OUT at bucket 7 → all outputs 0 asynchronously; after release, start re-scans from address 0.
6. start re-pulsed mid-scan and again in the done cycle → both are ignored; emit_cnt and the address sequence are unaffected.
